// File: rtl/stage_wb_pkg.sv
// Shared types and constants for the writeback/commit stage.
package stage_wb_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned SR_AW   = 3;
  localparam int unsigned CR_W    = 2;
  localparam int unsigned NSR_DEF = 5;
  localparam logic [XLEN-1:0] RESET_VEC_DEF = 32'h0000_0100;

  typedef enum logic [SR_AW-1:0] {
    SR_EPC     = 3'd0,
    SR_ECAUSE  = 3'd1,
    SR_EVEC    = 3'd2,
    SR_STATUS  = 3'd3,
    SR_INSTRET = 3'd4
  } sr_idx_e;

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_SCALL  = 2'd1,
    C_UDF    = 2'd2,
    C_DFAULT = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    KERNEL = 2'd1,
    HALT   = 2'd2
  } priv_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   nextpc;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   res;
    logic [REG_AW-1:0] rd;
    logic              w_rd;
    logic [CR_W-1:0]   cmp_res;
    logic              w_cr;
    logic              mtsr;
    logic              scall;
    logic              eret;
    logic              udf;
    logic              bubble;
  } mem_out_t;

endpackage

// File: rtl/stage_wb_if.sv
// Memory-stage to writeback-stage bundle, including regfile/SR side channels.
interface stage_wb_if;
  import stage_wb_pkg::*;

  mem_out_t          mem;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [CR_W-1:0]   cmp_reg;
  logic [CR_W-1:0]   scr;
  logic [SR_AW-1:0]  sr_raddr;
  logic [XLEN-1:0]   sr_rdata;
  logic              exn;
  logic [XLEN-1:0]   redirect_pc;
  logic              halted;

  modport master (
    output mem, sr_raddr,
    input  rf_we, rf_waddr, rf_wdata, cmp_reg, scr, sr_rdata, exn, redirect_pc, halted
  );

  modport slave (
    input  mem, sr_raddr,
    output rf_we, rf_waddr, rf_wdata, cmp_reg, scr, sr_rdata, exn, redirect_pc, halted
  );

endinterface

// File: rtl/stage_wb_sysregs.sv
// System register file: EPC, ECAUSE, EVEC, STATUS(scr), INSTRET with trap and mtsr update paths.
module wb_sysregs
  import stage_wb_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter int unsigned     NSR       = NSR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              trap,
  input  logic [XLEN-1:0]   trap_epc,
  input  cause_e            trap_cause,
  input  logic              trap_save_scr,
  input  logic [CR_W-1:0]   trap_scr,
  input  logic              mtsr_we,
  input  logic [SR_AW-1:0]  mtsr_idx,
  input  logic [XLEN-1:0]   mtsr_data,
  input  logic              retire,
  input  logic [SR_AW-1:0]  raddr,
  output logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   epc,
  output logic [XLEN-1:0]   evec,
  output logic [CR_W-1:0]   scr
);

  logic [XLEN-1:0] epc_q, ecause_q, evec_q, instret_q;
  logic [CR_W-1:0] scr_q;
  logic            wr_ok;
  logic            wr_epc, wr_ecause, wr_evec, wr_status, wr_instret;

  // EPC/ECAUSE are kernel-only; other registers take mtsr in either mode
  assign wr_ok      = mtsr_we && (32'(mtsr_idx) < NSR);
  assign wr_epc     = wr_ok && mode && (mtsr_idx == SR_EPC);
  assign wr_ecause  = wr_ok && mode && (mtsr_idx == SR_ECAUSE);
  assign wr_evec    = wr_ok && (mtsr_idx == SR_EVEC);
  assign wr_status  = wr_ok && (mtsr_idx == SR_STATUS);
  assign wr_instret = wr_ok && (mtsr_idx == SR_INSTRET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q     <= '0;
      ecause_q  <= '0;
      evec_q    <= RESET_VEC;
      scr_q     <= '0;
      instret_q <= '0;
    end else begin
      if (trap) begin
        epc_q    <= trap_epc;
        ecause_q <= 32'(trap_cause);
        if (trap_save_scr) scr_q <= trap_scr;
      end else begin
        if (wr_epc)    epc_q    <= mtsr_data;
        if (wr_ecause) ecause_q <= mtsr_data;
        if (wr_status) scr_q    <= mtsr_data[2:1];
      end
      if (wr_evec) evec_q <= {mtsr_data[XLEN-1:2], 2'b00};
      if (wr_instret)  instret_q <= mtsr_data;
      else if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  // Read port sees only committed state; same-cycle writes are not bypassed
  always_comb begin
    rdata = '0;
    if (32'(raddr) < NSR) begin
      case (raddr)
        SR_EPC:     rdata = epc_q;
        SR_ECAUSE:  rdata = ecause_q;
        SR_EVEC:    rdata = evec_q;
        SR_STATUS:  rdata = {29'b0, scr_q, mode};
        SR_INSTRET: rdata = instret_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign epc  = epc_q;
  assign evec = evec_q;
  assign scr  = scr_q;

endmodule

// File: rtl/stage_wb.sv
// Writeback/commit stage: GPR commit, compare register, privilege FSM and combinational flush.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter int unsigned     NSR       = NSR_DEF
) (
  input logic     clk,
  input logic     rst_n,
  stage_wb_if.slave wb
);

  priv_state_e     state_q, state_d;
  mem_out_t        m;
  logic            valid, is_udf, trap, eret_ok, commit;
  logic            exn, rf_we, save_scr;
  logic [XLEN-1:0] redirect_pc, trap_epc, epc, evec;
  cause_e          trap_cause;
  logic [CR_W-1:0] cmp_q, scr;

  assign m = wb.mem;

  // udf > scall > eret; eret outside KERNEL is an undefined instruction
  assign valid   = !m.bubble && (state_q != HALT);
  assign is_udf  = m.udf || (m.eret && (state_q == USER));
  assign trap    = valid && (is_udf || m.scall);
  assign eret_ok = valid && !trap && m.eret;
  assign commit  = valid && !trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= USER;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      USER:    if (trap) state_d = KERNEL;
      KERNEL: begin
        if (trap)         state_d = HALT;
        else if (eret_ok) state_d = USER;
      end
      HALT:    state_d = HALT;
      default: state_d = USER;
    endcase
  end

  always_comb begin
    exn         = 1'b0;
    redirect_pc = evec;
    trap_epc    = m.pc;
    trap_cause  = C_NONE;
    save_scr    = 1'b0;
    rf_we       = commit && m.w_rd && (m.rd != '0);
    if (state_q == HALT) begin
      exn = 1'b1;
    end else if (valid && (m.scall || m.udf || m.eret)) begin
      exn = 1'b1;
      if (eret_ok) redirect_pc = epc;
    end
    if (trap) begin
      if (state_q == KERNEL) begin
        trap_cause = C_DFAULT;
      end else if (is_udf) begin
        trap_cause = C_UDF;
      end else begin
        trap_cause = C_SCALL;
        trap_epc   = m.nextpc;
      end
      save_scr = (state_q == USER);
    end
  end

  // eret restores the saved bits, which the memory stage already placed in cmp_res
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cmp_q <= '0;
    else if (commit && (m.w_cr || m.eret)) cmp_q <= m.cmp_res;
  end

  wb_sysregs #(.RESET_VEC(RESET_VEC), .NSR(NSR)) u_sysregs (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (state_q == KERNEL),
    .trap          (trap),
    .trap_epc      (trap_epc),
    .trap_cause    (trap_cause),
    .trap_save_scr (save_scr),
    .trap_scr      (cmp_q),
    .mtsr_we       (commit && m.mtsr),
    .mtsr_idx      (m.rd[SR_AW-1:0]),
    .mtsr_data     (m.alu_res),
    .retire        (commit),
    .raddr         (wb.sr_raddr),
    .rdata         (wb.sr_rdata),
    .epc           (epc),
    .evec          (evec),
    .scr           (scr)
  );

  assign wb.rf_we       = rf_we;
  assign wb.rf_waddr    = m.rd;
  assign wb.rf_wdata    = m.res;
  assign wb.cmp_reg     = cmp_q;
  assign wb.scr         = scr;
  assign wb.exn         = exn;
  assign wb.redirect_pc = redirect_pc;
  assign wb.halted      = (state_q == HALT);

endmodule

// File: tb/tb_stage_wb.sv
// Directed and randomized checks of stage_wb against a behavioural commit model.
module tb_stage_wb;
  import stage_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_wb_if bus();

  stage_wb #(.RESET_VEC(32'h0000_0100), .NSR(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Architectural model: 0 user, 1 kernel, 2 halted
  int          m_st;
  logic [31:0] m_epc, m_ecause, m_evec, m_instret;
  logic [1:0]  m_scr, m_cmp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] i);
    case (i)
      3'd0:    return m_epc;
      3'd1:    return m_ecause;
      3'd2:    return m_evec;
      3'd3:    return {29'b0, m_scr, (m_st == 1)};
      3'd4:    return m_instret;
      default: return 32'h0;
    endcase
  endfunction

  function automatic mem_out_t nop();
    mem_out_t r;
    r = '0;
    return r;
  endfunction

  function automatic mem_out_t bubble();
    mem_out_t r;
    r = '0;
    r.bubble = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_epc = 0; m_ecause = 0; m_evec = 32'h100; m_instret = 0;
    m_scr = 0; m_cmp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.mem = bubble();
    bus.sr_raddr = 3'd0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_exn", 32'(bus.exn), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_cmp", 32'(bus.cmp_reg), 32'd0);
    check("rst_scr", 32'(bus.scr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.sr_raddr = 3'(i);
      #1;
      check($sformatf("rst_sr%0d", i), bus.sr_rdata, m_read(3'(i)));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one MEM word, check combinational outputs, then advance model across the edge
  task automatic step(input mem_out_t m, input logic [2:0] ra);
    logic v, udf_eff, trap, eret_ok, commit, e_exn, e_we;
    logic [31:0] e_redir;
    int o;
    @(negedge clk);
    bus.mem = m;
    bus.sr_raddr = ra;
    #1;
    o       = m_st;
    v       = !m.bubble && (o != 2);
    udf_eff = m.udf || (m.eret && o == 0);
    trap    = v && (udf_eff || m.scall);
    eret_ok = v && !trap && m.eret;
    commit  = v && !trap;
    e_exn   = (o == 2) || (v && (m.scall || m.udf || m.eret));
    e_redir = eret_ok ? m_epc : m_evec;
    e_we    = commit && m.w_rd && (m.rd != 0);
    check("rf_we", 32'(bus.rf_we), 32'(e_we));
    if (e_we) begin
      check("rf_waddr", 32'(bus.rf_waddr), 32'(m.rd));
      check("rf_wdata", bus.rf_wdata, m.res);
    end
    check("exn", 32'(bus.exn), 32'(e_exn));
    if (e_exn) check("redirect", bus.redirect_pc, e_redir);
    check("sr_rdata", bus.sr_rdata, m_read(ra));
    check("cmp_reg", 32'(bus.cmp_reg), 32'(m_cmp));
    check("scr", 32'(bus.scr), 32'(m_scr));
    check("halted", 32'(bus.halted), 32'(o == 2));
    @(posedge clk);
    if (trap) begin
      if (o == 1) begin
        m_st = 2; m_ecause = 3; m_epc = m.pc;
      end else begin
        m_st = 1;
        m_scr = m_cmp;
        m_ecause = udf_eff ? 32'd2 : 32'd1;
        m_epc = udf_eff ? m.pc : m.nextpc;
      end
    end
    if (commit) begin
      if (m.w_cr || m.eret) m_cmp = m.cmp_res;
      if (eret_ok) m_st = 0;
      if (m.mtsr && m.rd[2:0] == 3'd4) m_instret = m.alu_res;
      else m_instret = m_instret + 1;
      if (m.mtsr) begin
        case (m.rd[2:0])
          3'd0: if (o == 1) m_epc = m.alu_res;
          3'd1: if (o == 1) m_ecause = m.alu_res;
          3'd2: m_evec = m.alu_res & 32'hFFFF_FFFC;
          3'd3: m_scr = m.alu_res[2:1];
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle(input logic [2:0] ra);
    @(negedge clk);
    bus.mem = bubble();
    bus.sr_raddr = ra;
    #1;
  endtask

  mem_out_t mw;

  initial begin
    bus.mem = bubble();
    bus.sr_raddr = 3'd0;
    model_reset();
    do_reset();

    // Plain GPR commit
    mw = nop(); mw.w_rd = 1'b1; mw.rd = 5'd5; mw.res = 32'hDEAD_BEEF;
    step(mw, 3'd4);
    idle(3'd4); check("t1_instret", bus.sr_rdata, 32'd1);

    // rd=0 still retires; bubble does nothing
    mw.rd = 5'd0; step(mw, 3'd4);
    step(bubble(), 3'd4);
    idle(3'd4); check("t2_instret", bus.sr_rdata, 32'd2);
    check("t2_exn", 32'(bus.exn), 32'd0);

    // scall from USER with cmp_reg=10
    mw = nop(); mw.w_cr = 1'b1; mw.cmp_res = 2'b10; step(mw, 3'd0);
    mw = nop(); mw.scall = 1'b1; mw.pc = 32'h40; mw.nextpc = 32'h44; step(mw, 3'd2);
    idle(3'd0); check("t3_epc", bus.sr_rdata, 32'h44);
    idle(3'd1); check("t3_ecause", bus.sr_rdata, 32'd1);
    idle(3'd3); check("t3_status", bus.sr_rdata, 32'd5);
    check("t3_scr", 32'(bus.scr), 32'd2);

    // eret back to USER
    mw = nop(); mw.eret = 1'b1; mw.cmp_res = 2'b10; step(mw, 3'd0);
    idle(3'd3); check("t4_status", bus.sr_rdata, 32'd4);
    check("t4_cmp", 32'(bus.cmp_reg), 32'd2);

    // USER cannot write EPC; KERNEL EVEC write drops low bits
    mw = nop(); mw.mtsr = 1'b1; mw.rd = 5'd0; mw.alu_res = 32'h55; step(mw, 3'd0);
    idle(3'd0); check("t6_epc", bus.sr_rdata, 32'h44);
    mw = nop(); mw.scall = 1'b1; mw.pc = 32'h80; mw.nextpc = 32'h84; step(mw, 3'd0);
    mw = nop(); mw.mtsr = 1'b1; mw.rd = 5'd2; mw.alu_res = 32'h203; step(mw, 3'd2);
    idle(3'd2); check("t6_evec", bus.sr_rdata, 32'h200);

    // Double fault
    mw = nop(); mw.udf = 1'b1; mw.pc = 32'h120; step(mw, 3'd0);
    idle(3'd1); check("t5_ecause", bus.sr_rdata, 32'd3);
    idle(3'd0); check("t5_epc", bus.sr_rdata, 32'h120);
    check("t5_halted", 32'(bus.halted), 32'd1);
    check("t5_exn", 32'(bus.exn), 32'd1);
    check("t5_redir", bus.redirect_pc, 32'h200);
    mw = nop(); mw.w_rd = 1'b1; mw.rd = 5'd7; step(mw, 3'd4);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      mw = nop();
      mw.pc      = $urandom & 32'hFFFF_FFFC;
      mw.nextpc  = mw.pc + 32'd4;
      mw.alu_res = $urandom;
      mw.res     = $urandom;
      mw.rd      = 5'($urandom);
      mw.w_rd    = 1'($urandom);
      mw.cmp_res = 2'($urandom);
      mw.w_cr    = ($urandom_range(0, 3) == 0);
      case (r)
        0:       mw.bubble = 1'b1;
        1:       mw.scall = 1'b1;
        2:       mw.udf = 1'b1;
        3, 4:    mw.eret = 1'b1;
        5, 6, 7: mw.mtsr = 1'b1;
        8:       {mw.udf, mw.scall, mw.eret} = 3'($urandom);
        default: ;
      endcase
      step(mw, 3'($urandom));
      if ((m_st == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
